// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a NUM_REGS x 8-bit register file with pointer auto-increment,
// repeated START, read-back, a write-commit strobe and a host-side access port.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        scl_o,
  output logic                        sda_o,
  input  logic                        host_we,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          rw_q, rw_d;
  logic          sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic [7:0]    rx_byte, rd_byte;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign rx_byte = {sr_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];
  assign ptr_inc = (ptr_q == AW'(NUM_REGS - 1)) ? '0 : ptr_q + AW'(1);

  assign scl_o      = 1'b1;
  assign sda_o      = sda_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_addr];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_d       = sda_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: if (scl_rise) begin
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              if (32'(rx_byte) < NUM_REGS) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = PTR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_inc;
              state_d     = WDATA_ACK;
            end
          end
        end
        // bit_cnt 0: fall ending bit 8 starts the ACK; bit_cnt 1: fall ending the ACK clock
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_d     = 1'b0;
            bit_cnt_d = 4'd1;
          end else if (state_q == ADDR_ACK && rw_q) begin
            sda_d     = rd_byte[7];
            sr_d      = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = RDATA;
          end else begin
            sda_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = (state_q == ADDR_ACK) ? PTR : WDATA;
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_d     = 1'b1;
            bit_cnt_d = '0;
            state_d   = RDATA_ACK;
          end else begin
            sda_d     = sr_q[7];
            sr_d      = {sr_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // ptr advances at the ACK sample so the following fall loads the next register
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_inc;
              bit_cnt_d = 4'd1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            sda_d     = rd_byte[7];
            sr_d      = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_strobe_d) regs_d[ptr_q] = rx_byte;
    if (host_we) regs_d[host_addr] = host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master against a transaction-level register/pointer model;
// a per-cycle monitor checks commit strobes and host reads against that model.
module tb_i2c_slave_regfile;
  localparam int unsigned NREGS = 16;
  localparam int SYNC = 2;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_i, sda_i, scl_o, sda_o;
  logic host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] mregs [NREGS];
  int unsigned mptr = 0;
  logic [11:0] exp_q [$];
  logic watch_quiet = 1'b0;

  assign scl_i = scl_m & scl_o;
  assign sda_i = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h42), .NUM_REGS(NREGS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle out of reset, check strobes and host_rdata against the model.
  initial begin
    logic hw;
    logic [3:0] ha;
    logic [7:0] hd;
    logic [11:0] e;
    forever begin
      @(posedge clk);
      hw = host_we; ha = host_addr; hd = host_wdata;
      #1;
      if (!rst_n) begin
        foreach (mregs[i]) mregs[i] = '0;
        exp_q.delete();
      end else begin
        if (wr_strobe) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wr_strobe: got addr=%0d data=0x%0h, expected no strobe", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_commit", {wr_addr, wr_data}, e);
            mregs[e[11:8]] = e[7:0];
          end
        end
        if (hw) mregs[ha] = hd;
        check("host_rdata", host_rdata, mregs[host_addr]);
        check("scl_o", scl_o, 1);
        if (watch_quiet) begin
          check("quiet_sda", sda_o, 1);
          check("quiet_busy", busy, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    if (!scl_m) begin tick(Q); scl_m = 1'b1; end
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
    tick(SYNC + 3);
    check("busy_after_stop", busy, 0);
    check("sda_after_stop", sda_o, 1);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit collide, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q); scl_m = 1'b1;
      if (collide && i == 0) begin
        tick(SYNC); host_we = 1'b1; tick(1); host_we = 1'b0; tick(2*Q - SYNC - 1);
      end else tick(2*Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); ack = sda_i; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick(Q); scl_m = 1'b1; tick(Q); b[i] = sda_i; tick(Q); scl_m = 1'b0; tick(Q);
    end
    sda_m = nack; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; sda_m = 1'b1; tick(Q);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1; tick(1); host_we = 1'b0;
  endtask

  task automatic wr_txn(input logic [6:0] a7, input logic [7:0] p, input int n,
                        input logic [7:0] d [4], input bit do_stop, input int collide_idx);
    logic ack;
    bit valid;
    i2c_start();
    write_byte({a7, 1'b0}, 1'b0, ack);
    check("addr_ack", ack, (a7 == 7'h42) ? 0 : 1);
    if (a7 == 7'h42) check("busy_after_match", busy, 1);
    valid = (a7 == 7'h42) && (32'(p) < NREGS);
    if (valid) mptr = p;
    write_byte(p, 1'b0, ack);
    check("ptr_ack", ack, valid ? 0 : 1);
    for (int k = 0; k < n; k++) begin
      if (valid) begin
        exp_q.push_back({4'(mptr), d[k]});
        mptr = (mptr + 1) % NREGS;
      end
      write_byte(d[k], k == collide_idx, ack);
      check("data_ack", ack, valid ? 0 : 1);
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic rd_txn(input int n, output logic [7:0] got [4]);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte({7'h42, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", ack, 0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      got[k] = b;
      check("rd_data", b, mregs[mptr]);
      if (k != n - 1) mptr = (mptr + 1) % NREGS;
    end
    tick(SYNC + 3);
    check("sda_released_after_nack", sda_o, 1);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic ack;
    int op;

    tick(3);
    check("rst_sda_o", sda_o, 1);
    check("rst_scl_o", scl_o, 1);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_host_rdata", host_rdata, 0);
    rst_n = 1'b1;
    tick(3);

    // Write burst
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    wr_txn(7'h42, 8'h03, 2, d, 1'b1, -1);
    host_addr = 4'd3; tick(1); check("burst_reg3", host_rdata, 8'hA5);
    host_addr = 4'd4; tick(1); check("burst_reg4", host_rdata, 8'h5A);

    // Read with wrap via repeated START
    host_write(4'd14, 8'h11); host_write(4'd15, 8'h22); host_write(4'd0, 8'h33);
    wr_txn(7'h42, 8'h0E, 0, d, 1'b0, -1);
    rd_txn(3, got);
    check("wrap_rd0", got[0], 8'h11);
    check("wrap_rd1", got[1], 8'h22);
    check("wrap_rd2", got[2], 8'h33);

    // Address mismatch
    watch_quiet = 1'b1;
    d = '{8'h12, 8'h34, 8'h00, 8'h00};
    wr_txn(7'h43, 8'h01, 2, d, 1'b1, -1);
    watch_quiet = 1'b0;

    // Invalid pointer, data must be ignored
    wr_txn(7'h42, 8'h20, 2, d, 1'b1, -1);
    for (int a = 0; a < 16; a++) begin host_addr = 4'(a); tick(1); end

    // Host/I2C collision on reg 2
    host_addr = 4'd2; host_wdata = 8'h77;
    d = '{8'h99, 8'h00, 8'h00, 8'h00};
    wr_txn(7'h42, 8'h02, 1, d, 1'b1, 0);
    tick(1);
    check("collision_reg2", host_rdata, 8'h77);

    // Randomized traffic
    for (int it = 0; it < 18; it++) begin
      op = $urandom_range(0, 3);
      foreach (d[i]) d[i] = 8'($urandom);
      case (op)
        0: begin
          host_write(4'($urandom), 8'($urandom));
          host_write(4'($urandom), 8'($urandom));
        end
        1: begin
          if ($urandom_range(0, 7) == 0) begin
            watch_quiet = 1'b1;
            wr_txn(7'h43, 8'($urandom_range(0, 19)), $urandom_range(0, 3), d, 1'b1, -1);
            watch_quiet = 1'b0;
          end else begin
            wr_txn(7'h42, 8'($urandom_range(0, 19)), $urandom_range(0, 3), d, 1'b1, -1);
          end
        end
        2: begin
          wr_txn(7'h42, 8'($urandom_range(0, 15)), $urandom_range(0, 2), d, 1'b0, -1);
          rd_txn($urandom_range(1, 3), got);
        end
        default: rd_txn($urandom_range(1, 3), got);
      endcase
    end

    // Reset while the slave drives a 0 on SDA
    host_write(4'd5, 8'h3C);
    wr_txn(7'h42, 8'h05, 0, d, 1'b0, -1);
    i2c_start();
    write_byte({7'h42, 1'b1}, 1'b0, ack);
    check("mid_rd_addr_ack", ack, 0);
    tick(Q);
    check("mid_rd_sda_low", sda_o, 0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_sda_o", sda_o, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_strobe", wr_strobe, 0);
    for (int a = 0; a < 16; a++) begin
      host_addr = 4'(a); #1;
      check("rst_mid_reg_zero", host_rdata, 0);
    end
    tick(2);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    rst_n = 1'b1;
    mptr = 0;
    tick(4);
    d = '{8'hE1, 8'h00, 8'h00, 8'h00};
    wr_txn(7'h42, 8'h07, 1, d, 1'b1, -1);
    wr_txn(7'h42, 8'h07, 0, d, 1'b0, -1);
    rd_txn(1, got);
    check("post_reset_rd", got[0], 8'hE1);

    tick(4);
    check("pending_commits", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C slave exposing a NUM_REGS x 8-bit register file to an external I2C master, with both write and read transfers, register-pointer auto-increment, repeated START, and a host-side access port.

- Successor to the team's receive-only slave:
  - adds address matching against a parameter
  - adds read-back, input synchronisers and a write-commit strobe
- Sits between the board-level I2C pads (open-drain buffers outside this block) and on-chip control logic.

## Interface
- SLAVE_ADDR, 7'h42, 7-bit slave address matched in the address byte.
- NUM_REGS, 16, register count; legal range 2..256.
- SYNC_STAGES, 2, synchroniser depth for scl_i/sda_i; legal range 2..4.

- clk  in  1  system clock; must be at least 16x the SCL frequency.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- scl_o  out  1  SCL drive; 0 pulls low, 1 releases. Tied to 1 (no clock stretching).
- sda_o  out  1  SDA drive; 0 pulls low, 1 releases.
- host_we  in  1  host write enable.
- host_addr  in  $clog2(NUM_REGS)  host register index.
- host_wdata  in  8  host write data.
- host_rdata  out  8  combinational read of reg[host_addr].
- wr_strobe  out  1  one-cycle pulse when an I2C write byte commits.
- wr_addr  out  $clog2(NUM_REGS)  index of the committed register; valid with wr_strobe.
- wr_data  out  8  committed byte; valid with wr_strobe.
- busy  out  1  high from an address match until STOP, or until a START that does not match.

## Operation
- **Synchronisers:** scl_i/sda_i pass through SYNC_STAGES flops, then one extra flop for edge detection. All protocol decisions use the synced values.
- **Bus conditions (synced SCL high):**
  - START: SDA falling.
  - STOP: SDA rising.
  - Either condition overrides every state.
  - START -> ADDR, bit_count=0, sda_o=1.
  - STOP -> IDLE, sda_o=1, busy=0.
- **Bit timing:** data bits are sampled on SCL rising and shifted MSB-first. sda_o changes only on detected SCL falling.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **ADDR:** after 8 bits, compare bits[7:1] with SLAVE_ADDR.
  - Match: -> ADDR_ACK, busy=1.
  - Mismatch: -> IGNORE, no ACK.
- **ADDR_ACK:** drive sda_o=0 for one SCL clock.
  - R/W=0 -> PTR.
  - R/W=1: load reg[ptr] into the shift register -> RDATA.
- **PTR:** 8-bit pointer byte.
  - Value < NUM_REGS: ptr=value, ACK, -> WDATA.
  - Otherwise: NACK (sda_o stays 1), ptr unchanged, -> IGNORE.
- **WDATA:** 8 bits.
  - At the SCL rising that samples bit 0: reg[ptr]=byte, wr_strobe=1, wr_addr=ptr, wr_data=byte.
  - Then ptr = (ptr==NUM_REGS-1) ? 0 : ptr+1.
  - ACK via WDATA_ACK, then back to WDATA.
- **RDATA:** slave drives 8 bits from the shift register, MSB-first, then releases SDA -> RDATA_ACK.
  - Master ACK (0): ptr increments with wrap, the next byte loads, -> RDATA.
  - Master NACK (1): -> IGNORE.
- **IGNORE:** sda_o=1. Exits only on START or STOP.
- **Repeated START:** keeps ptr. Writing a pointer then repeated-START read returns reg[ptr].
- **Host/I2C write collision:** if the host writes the same register in the same cycle as an I2C commit, host_wdata wins; wr_strobe still pulses with the I2C byte.
- **Host visibility:** host writes become visible to I2C reads at the next byte load.

## Timing
- **Reset values:**
  - sda_o=1, scl_o=1, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - All registers 0, ptr=0, state IDLE.
- **Reset mid-transfer:** same as above, immediately and asynchronously. sda_o is released within the reset assertion.
- **Input latency:** SYNC_STAGES+1 clk from a pad edge to edge detection.
- **SDA drive:** sda_o updates 1 clk after the SCL falling is detected.
  - ACK drive starts after the falling edge that ends bit 8.
  - ACK drive is released after the falling edge that ends the ACK clock.
  - The read MSB is driven at that same release point.
- **Write commit:** wr_strobe, wr_addr, wr_data and the register update occur 1 clk after the rising edge of bit 8 is detected. wr_strobe is high exactly 1 clk.
- **host_rdata:** combinational, zero latency; reflects a host write on the next clk.
- **busy:** rises 1 clk after address-match detection; falls 1 clk after STOP detection.

## Test plan
- **Write burst:** master writes addr 0x42/W, ptr 0x03, data 0xA5, 0x5A.
  - ACK on all 4 bytes.
  - wr_strobe pulses twice: (3, 0xA5) then (4, 0x5A).
  - host_rdata at addr 3 = 0xA5, at addr 4 = 0x5A.
- **Read with auto-increment:** host preloads reg14=0x11, reg15=0x22, reg0=0x33. Master sends 0x42/W, ptr 0x0E, repeated START, 0x42/R, reads 3 bytes ACK/ACK/NACK.
  - Reads 0x11, 0x22, 0x33 (wrap at 15 -> 0).
  - sda_o released after the NACK.
- **Address mismatch:** master sends 0x43/W and data.
  - sda_o stays 1 throughout, busy stays 0, no wr_strobe.
- **Invalid pointer:** master sends 0x42/W, ptr 0x20 with NUM_REGS=16.
  - Address ACKed, pointer NACKed.
  - Following data is ignored; no register changes.
- **Reset mid-read:** assert rst_n low while the slave drives 0 on SDA.
  - sda_o=1 immediately, all registers read 0, busy=0.
  - Next transfer operates normally.
- **Host/I2C collision:** host writes 0x77 to reg 2 in the same cycle as an I2C commit of 0x99 to reg 2.
  - reg2 = 0x77.
  - wr_strobe pulses with wr_data=0x99.
